fsm_seq_gen: RTL

FSM_SEQ_GEN -- requirements
Module: fsm_seq_gen

---
 rtl/fsm_seq_gen_if.sv | 22 ++
 rtl/fsm_seq_gen.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/fsm_seq_gen_if.sv
// Request handshake bundle between a requester and fsm_seq_gen.
// Plain wires, no storage; the slave side owns req_ready, busy and done.
interface fsm_seq_gen_if #(
    parameter int HOLD_W = 4
);
    logic              req_valid;
    logic [1:0]        req_target;
    logic [HOLD_W-1:0] req_hold;
    logic              req_ready;
    logic              busy;
    logic              done;

    modport master (
        output req_valid, req_target, req_hold,
        input  req_ready, busy, done
    );

    modport slave (
        input  req_valid, req_target, req_hold,
        output req_ready, busy, done
    );
endinterface

// File: rtl/fsm_seq_gen.sv
// Steers a 4-state machine (start/odd/even/fin) via q1/q2 to a target and parks; optional checker under FSM_SEQ_GEN_CHECK_EN.
// Latency: done pulses the cycle after edge L+req_hold+1 from accept (L = shortest path length).
// Backpressure: req_ready only in IDLE and out of reset; req_valid while busy is dropped without effect.
module fsm_seq_gen #(
    parameter int HOLD_W = 4
) (
    input  logic          clk,
    input  logic          reset,
    fsm_seq_gen_if.slave  req,
    output logic          q1,
    output logic          q2,
    output logic [1:0]    model_state,
    input  logic [1:0]    dut_count,
    output logic          mismatch
);
    localparam logic [1:0] S_START = 2'b00;
    localparam logic [1:0] S_ODD   = 2'b01;
    localparam logic [1:0] S_EVEN  = 2'b10;
    localparam logic [1:0] S_FIN   = 2'b11;

    typedef enum logic [1:0] {IDLE, DRIVE, HOLD} ctl_t;

    ctl_t              state, state_nxt;
    logic [1:0]        q, q_nxt;
    logic [1:0]        model_nxt;
    logic [1:0]        tgt, tgt_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic              done_r, done_nxt;

    // Driven machine's transition on input code c = {q1,q2}.
    function automatic logic [1:0] model_step(input logic [1:0] m, input logic [1:0] c);
        logic [1:0] r;
        r = S_START;
        case (m)
            S_START: r = (c == 2'b01) ? S_ODD : S_START;
            S_ODD: begin
                case (c)
                    2'b10:   r = S_EVEN;
                    2'b01:   r = S_ODD;
                    default: r = S_START;
                endcase
            end
            default: begin
                case (c)
                    2'b01:   r = S_ODD;
                    2'b11:   r = S_FIN;
                    default: r = S_START;
                endcase
            end
        endcase
        return r;
    endfunction

    function automatic logic [1:0] park(input logic [1:0] s);
        logic [1:0] r;
        r = 2'b00;
        if (s == S_ODD) r = 2'b01;
        else if (s == S_FIN) r = 2'b11;
        return r;
    endfunction

    // First code of the shortest path; only called when from != to.
    function automatic logic [1:0] first_code(input logic [1:0] from, input logic [1:0] to);
        logic [1:0] r;
        r = 2'b00;
        case (to)
            S_START: r = 2'b00;
            S_ODD:   r = 2'b01;
            S_EVEN:  r = (from == S_ODD) ? 2'b10 : 2'b01;
            default: begin
                case (from)
                    S_EVEN:  r = 2'b11;
                    S_ODD:   r = 2'b10;
                    S_START: r = 2'b01;
                    default: r = 2'b11;
                endcase
            end
        endcase
        return r;
    endfunction

    always_comb begin
        model_nxt = model_step(model_state, q);
        state_nxt = state;
        q_nxt     = q;
        tgt_nxt   = tgt;
        hold_nxt  = hold_cnt;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                q_nxt = park(model_nxt);
                if (req.req_valid) begin
                    tgt_nxt  = req.req_target;
                    // even cannot be held: parking there falls back to start
                    hold_nxt = (req.req_target == S_EVEN) ? '0 : req.req_hold;
                    if (model_nxt == req.req_target) begin
                        q_nxt     = park(req.req_target);
                        state_nxt = HOLD;
                    end else begin
                        q_nxt     = first_code(model_nxt, req.req_target);
                        state_nxt = DRIVE;
                    end
                end
            end
            DRIVE: begin
                if (model_nxt == tgt) begin
                    q_nxt     = park(tgt);
                    state_nxt = HOLD;
                end else begin
                    q_nxt = first_code(model_nxt, tgt);
                end
            end
            HOLD: begin
                q_nxt = park(tgt);
                if (hold_cnt == '0) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                    q_nxt     = park(model_nxt);
                end else begin
                    hold_nxt = hold_cnt - HOLD_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            q           <= 2'b00;
            model_state <= S_START;
            tgt         <= S_START;
            hold_cnt    <= '0;
            done_r      <= 1'b0;
        end else begin
            state       <= state_nxt;
            q           <= q_nxt;
            model_state <= model_nxt;
            tgt         <= tgt_nxt;
            hold_cnt    <= hold_nxt;
            done_r      <= done_nxt;
        end
    end

    assign q1            = q[1];
    assign q2            = q[0];
    assign req.req_ready = (state == IDLE) && !reset;
    assign req.busy      = (state != IDLE);
    assign req.done      = done_r;

`ifdef FSM_SEQ_GEN_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            mismatch <= 1'b0;
        end else if (dut_count != model_state) begin
            mismatch <= 1'b1;
        end
    end
`else
    logic unused_dut_count;
    assign unused_dut_count = ^dut_count;
    assign mismatch         = 1'b0;
`endif
endmodule
